// File: rtl/keypad_scan_if.sv
// Keypad scanner signal bundle: row drive and column sense toward the pad ring,
// accepted keycode and newkey pulse toward the lock-compare stage.
interface keypad_scan_if;
    logic [3:0] col;
    logic [3:0] row;
    logic [4:0] keycode;
    logic       newkey;

    modport master (
        input  col,
        output row,
        output keycode,
        output newkey
    );

    modport slave (
        output col,
        input  row,
        input  keycode,
        input  newkey
    );
endinterface

// File: rtl/keypad_scan.sv
// 4x4 keypad row scanner with press/release debounce and a one-cycle newkey strobe.
// Optional auto-repeat while a key is held: define KEYPAD_REPEAT_EN.
module keypad_scan #(
    parameter int unsigned SCAN_DIV = 4,
    parameter int unsigned DEBOUNCE = 8,
    parameter int unsigned REPEAT   = 64
) (
    input  logic          clk5,
    input  logic          reset,
    keypad_scan_if.master kp
);

    if (SCAN_DIV < 2 || SCAN_DIV > 255 || DEBOUNCE < 1 || DEBOUNCE > 255 ||
        REPEAT < 2 || REPEAT > 1023) begin : g_param_check
        $error("keypad_scan: parameter out of range");
    end

    localparam logic [7:0] DivLast = 8'(SCAN_DIV - 1);
    localparam logic [7:0] DebLim  = 8'(DEBOUNCE);

    typedef enum logic [1:0] {StScan, StDebounce, StPressed, StRelease} state_e;

    state_e     state_q;
    logic [1:0] r_q;
    logic [1:0] c_q;
    logic [7:0] div_q;
    logic [7:0] cnt_q;
    logic [3:0] row_q;
    logic [4:0] keycode_q;
    logic       newkey_q;

`ifdef KEYPAD_REPEAT_EN
    localparam logic [9:0] RepLast = 10'(REPEAT - 1);
    logic [9:0] rep_q;
`endif

    logic [3:0] col_low;
    logic       one_low;
    logic [1:0] low_idx;
    logic [3:0] cap_pat;

    function automatic logic [3:0] row_drive(input logic [1:0] idx);
        return ~(4'b0001 << idx);
    endfunction

    // A press is only a candidate when exactly one column line is pulled low.
    always_comb begin
        col_low = ~kp.col;
        one_low = (col_low != 4'b0000) && ((col_low & (col_low - 4'd1)) == 4'b0000);
        case (col_low)
            4'b0010: low_idx = 2'd1;
            4'b0100: low_idx = 2'd2;
            4'b1000: low_idx = 2'd3;
            default: low_idx = 2'd0;
        endcase
        cap_pat = ~(4'b0001 << c_q);
    end

    always_ff @(posedge clk5) begin
        if (!reset) begin
            state_q   <= StScan;
            r_q       <= 2'd0;
            c_q       <= 2'd0;
            div_q     <= 8'd0;
            cnt_q     <= 8'd0;
            row_q     <= 4'b1110;
            keycode_q <= 5'b00000;
            newkey_q  <= 1'b0;
`ifdef KEYPAD_REPEAT_EN
            rep_q     <= 10'd0;
`endif
        end else begin
            newkey_q <= 1'b0;
            unique case (state_q)
                StScan: begin
                    if (div_q == DivLast) begin
                        div_q <= 8'd0;
                        if (one_low) begin
                            state_q <= StDebounce;
                            c_q     <= low_idx;
                            cnt_q   <= 8'd0;
                        end else begin
                            r_q   <= r_q + 2'd1;
                            row_q <= row_drive(r_q + 2'd1);
                        end
                    end else begin
                        div_q <= div_q + 8'd1;
                    end
                end
                StDebounce: begin
                    if (kp.col != cap_pat) begin
                        state_q <= StScan;
                        r_q     <= r_q + 2'd1;
                        row_q   <= row_drive(r_q + 2'd1);
                        div_q   <= 8'd0;
                    end else if (cnt_q == DebLim) begin
                        state_q   <= StPressed;
                        keycode_q <= {1'b1, r_q, c_q};
                        newkey_q  <= 1'b1;
`ifdef KEYPAD_REPEAT_EN
                        rep_q     <= 10'd0;
`endif
                    end else begin
                        cnt_q <= cnt_q + 8'd1;
                    end
                end
                StPressed: begin
                    if (kp.col == 4'b1111) begin
                        state_q <= StRelease;
                        cnt_q   <= 8'd0;
                    end
`ifdef KEYPAD_REPEAT_EN
                    else if (rep_q == RepLast) begin
                        rep_q    <= 10'd0;
                        newkey_q <= 1'b1;
                    end else begin
                        rep_q <= rep_q + 10'd1;
                    end
`endif
                end
                StRelease: begin
                    // Any low column is release bounce: fall back to held, silently.
                    if (kp.col != 4'b1111) begin
                        state_q <= StPressed;
`ifdef KEYPAD_REPEAT_EN
                        rep_q   <= 10'd0;
`endif
                    end else if (cnt_q == DebLim) begin
                        state_q <= StScan;
                        r_q     <= 2'd0;
                        row_q   <= 4'b1110;
                        div_q   <= 8'd0;
                    end else begin
                        cnt_q <= cnt_q + 8'd1;
                    end
                end
            endcase
        end
    end

    assign kp.row     = row_q;
    assign kp.keycode = keycode_q;
    assign kp.newkey  = newkey_q;

endmodule

// File: doc/keypad_scan.md
KEYPAD_SCAN -- requirements
Module: keypad_scan

Interface
REQ-001 Parameter SCAN_DIV, 4: clock cycles each row is driven before its columns are sampled (range 2..255).
REQ-002 Parameter DEBOUNCE, 8: consecutive stable cycles required to accept a press or a release (range 1..255).
REQ-003 Parameter REPEAT, 64: cycles between auto-repeat pulses; used only with KEYPAD_REPEAT_EN (range 2..1023).
REQ-004 clk5  input  1  system clock; all state updates on rising edge.
REQ-005 reset  input  1  synchronous, active-low reset; acts on the rising edge of clk5 while 0.
REQ-006 col  input  4  keypad column lines, active-low; already synchronised to clk5 by the pad ring.
REQ-007 row  output  4  keypad row drive, active-low; exactly one bit is 0 in SCAN; the captured row bit is 0 in all other states.
REQ-008 keycode  output  5  {valid, row[1:0], col[1:0]} of the last accepted key; held until the next accepted key.
REQ-009 newkey  output  1  one-cycle pulse marking a newly accepted key; feeds the lock-compare stage together with keycode.

Function
REQ-010 The FSM SHALL have four states: SCAN, DEBOUNCE, PRESSED and RELEASE.
REQ-011 In SCAN, row index r SHALL advance 0->1->2->3->0 every SCAN_DIV cycles, with row = ~(4'b0001 << r).
REQ-012 The columns SHALL be sampled on the last cycle of each row dwell: exactly one col bit low -> capture r and that column index c, clear the counter, go to DEBOUNCE; no bit low or more than one bit low -> continue scanning.
REQ-013 In DEBOUNCE, the row SHALL stay frozen at r; a col value equal to the captured pattern -> counter++, any other value -> return to SCAN at row r+1 (mod 4) with no output change.
REQ-014 When the counter reaches DEBOUNCE, the FSM SHALL go to PRESSED; on that same edge keycode <= {1'b1, r[1:0], c[1:0]} and newkey <= 1.
REQ-015 newkey SHALL be high for exactly one cycle per accepted press, i.e. DEBOUNCE+1 cycles after the detecting sample edge.
REQ-016 In PRESSED, col == 4'b1111 -> go to RELEASE with the counter cleared; any other col value -> hold.
REQ-017 In RELEASE, the counter SHALL increment while col == 4'b1111; when it reaches DEBOUNCE the FSM goes to SCAN at row 0.
REQ-018 In RELEASE, any col bit low SHALL return the FSM to PRESSED with no newkey (release bounce).
REQ-019 A second key pressed while one is held SHALL be ignored until a full release has been accepted.
REQ-020 The counter SHALL saturate at its terminal value and never wrap.
REQ-021 The scan divider SHALL wrap from SCAN_DIV-1 to 0.

Reset
REQ-022 While reset = 0 at a clock edge, the block SHALL load: state = SCAN, r = 0, row = 4'b1110, keycode = 5'b00000, newkey = 0, all counters 0.
REQ-023 A reset asserted mid-press SHALL drop any pending or held key; keycode clears to 0 and no newkey is issued.
REQ-024 The first scan sample after reset release SHALL occur SCAN_DIV cycles after the first non-reset edge.

Configuration
REQ-025 With KEYPAD_REPEAT_EN defined: while in PRESSED, a repeat counter SHALL pulse newkey for one cycle every REPEAT cycles after the initial pulse, with keycode unchanged; the counter clears on entering PRESSED from either DEBOUNCE or RELEASE.
REQ-026 With KEYPAD_REPEAT_EN undefined, no repeat logic SHALL exist and each press SHALL yield exactly one newkey.

Verification
REQ-027 Reset 3 cycles, then row 0 col 1 held low 40 cycles -> keycode = 5'b10001, exactly one newkey pulse, DEBOUNCE+1 cycles after the detecting sample.
REQ-028 Sequence of presses row0/col2, row2/col1, row1/col2, each held 30 cycles with 30 released -> keycode = 10010, 11001, 10110 in order, exactly three newkey pulses.
REQ-029 Press row3 col0 that bounces high once at debounce count 5 -> no newkey, scan resumes at row 0; a clean retry -> keycode = 5'b11100.
REQ-030 Held key whose release bounces low 2 cycles into RELEASE -> returns to PRESSED, no extra newkey; a clean release -> back in SCAN after DEBOUNCE cycles.
REQ-031 Two columns low on one row, or reset asserted during DEBOUNCE -> no newkey; after reset keycode = 0 and row = 1110.
REQ-032 With KEYPAD_REPEAT_EN defined, a key held 200 cycles with REPEAT = 64 -> 1 + 3 newkey pulses spaced 64 cycles apart.
